spi_reg_bank: RTL

//  Register bank directly downstream of the SPI slave front end. Consumes the decoded
//  rw/addr/data strobes, performs register writes, and returns read data on data_word_send

---
 rtl/spi_reg_bank_if.sv | 29 ++
 rtl/spi_reg_bank.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank_if.sv
// Register-bank side of the SPI slave front end: operation strobes, address,
// write data and returned read data.
//
// Strobe semantics: an operation is taken on a rising master_clock edge when
// reg_operate is high. spi_write selects a write. spi_read selects a read only
// when spi_write is low. There is no backpressure: the bank accepts every
// operation. Read data appears on data_word_send one cycle after the strobe
// and is held until the next accepted read.
interface spi_reg_bank_if #(
  parameter int ADDR_LEN = 8,
  parameter int WORD_LEN = 16
) ();
  logic                reg_operate;
  logic                spi_write;
  logic                spi_read;
  logic [ADDR_LEN-1:0] spi_addr;
  logic [WORD_LEN-1:0] spi_data;
  logic [WORD_LEN-1:0] data_word_send;

  modport master (
    output reg_operate, spi_write, spi_read, spi_addr, spi_data,
    input  data_word_send
  );

  modport slave (
    input  reg_operate, spi_write, spi_read, spi_addr, spi_data,
    output data_word_send
  );
endinterface

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI slave. Holds the ID, control, sticky W1C status,
// IRQ mask, write/error counters and general-purpose registers. Returns read
// data with one cycle of latency.
module spi_reg_bank #(
  parameter int              SPI_ADDR_LEN = 8,
  parameter int              SPI_WORD_LEN = 16,
  parameter int              NUM_GP       = 4,
  parameter logic [SPI_WORD_LEN-1:0] DEVICE_ID  = 16'h5A01,
  parameter logic [SPI_WORD_LEN-1:0] CTRL_RESET = 16'h0000
) (
  input  logic                           master_clock,
  input  logic                           i_rst_n,
  spi_reg_bank_if.slave                  bus,
  input  logic [SPI_WORD_LEN-1:0]        i_event,
  input  logic [SPI_WORD_LEN-1:0]        i_status_in,
  output logic [SPI_WORD_LEN-1:0]        o_ctrl,
  output logic                           o_ctrl_wr,
  output logic [NUM_GP*SPI_WORD_LEN-1:0] o_gp,
  output logic                           o_irq
);

  localparam int A = SPI_ADDR_LEN;
  localparam int W = SPI_WORD_LEN;

  localparam logic [A-1:0] ADDR_ID      = A'(8'h00);
  localparam logic [A-1:0] ADDR_CTRL    = A'(8'h01);
  localparam logic [A-1:0] ADDR_STATUS  = A'(8'h02);
  localparam logic [A-1:0] ADDR_MASK    = A'(8'h03);
  localparam logic [A-1:0] ADDR_IN      = A'(8'h04);
  localparam logic [A-1:0] ADDR_WRCOUNT = A'(8'h05);
  localparam logic [A-1:0] ADDR_ERRADDR = A'(8'h06);
  localparam logic [A-1:0] ADDR_ERRCNT  = A'(8'h07);
  localparam int           GP_BASE      = 16;

  logic [NUM_GP-1:0][W-1:0] gp_q;
  logic [W-1:0]             status_q;
  logic [W-1:0]             mask_q;
  logic [W-1:0]             wr_count_q;
  logic [A-1:0]             err_addr_q;
  logic [W-1:0]             err_count_q;

  logic                     wr_acc;
  logic                     rd_acc;
  logic [NUM_GP-1:0]        gp_sel;
  logic                     gp_hit;
  logic                     writable;
  logic                     readable;
  logic                     log_err;
  logic [W-1:0]             rd_data;
  logic [W-1:0]             status_nxt;
  logic [W-1:0]             mask_nxt;

  assign o_gp = gp_q;

  // Decode the operation, build the read mux and the next-state status/mask.
  always_comb begin
    wr_acc = bus.reg_operate & bus.spi_write;
    rd_acc = bus.reg_operate & bus.spi_read & ~bus.spi_write;

    gp_sel  = '0;
    gp_hit  = 1'b0;
    rd_data = '0;
    for (int k = 0; k < NUM_GP; k++) begin
      if (bus.spi_addr == A'(GP_BASE + k)) begin
        gp_sel[k] = 1'b1;
        gp_hit    = 1'b1;
        rd_data   = gp_q[k];
      end
    end

    writable = gp_hit || bus.spi_addr == ADDR_CTRL ||
               bus.spi_addr == ADDR_STATUS || bus.spi_addr == ADDR_MASK;
    readable = writable;
    case (bus.spi_addr)
      ADDR_ID:      begin rd_data = DEVICE_ID;      readable = 1'b1; end
      ADDR_CTRL:    rd_data = o_ctrl;
      ADDR_STATUS:  rd_data = status_q;
      ADDR_MASK:    rd_data = mask_q;
      ADDR_IN:      begin rd_data = i_status_in;    readable = 1'b1; end
      ADDR_WRCOUNT: begin rd_data = wr_count_q;     readable = 1'b1; end
      ADDR_ERRADDR: begin rd_data = W'(err_addr_q); readable = 1'b1; end
      ADDR_ERRCNT:  begin rd_data = err_count_q;    readable = 1'b1; end
      default:      ;
    endcase

    log_err = (wr_acc & ~writable) | (rd_acc & ~readable);

    // Events are ORed in after the clear so a same-cycle set wins.
    status_nxt = status_q;
    if (wr_acc && bus.spi_addr == ADDR_STATUS) begin
      status_nxt = status_q & ~bus.spi_data;
    end
    status_nxt = status_nxt | i_event;

    mask_nxt = mask_q;
    if (wr_acc && bus.spi_addr == ADDR_MASK) begin
      mask_nxt = bus.spi_data;
    end
  end

  // Register writes, sticky status, mask and the registered interrupt.
  always_ff @(posedge master_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_ctrl    <= CTRL_RESET;
      o_ctrl_wr <= 1'b0;
      gp_q      <= '0;
      status_q  <= '0;
      mask_q    <= '0;
      o_irq     <= 1'b0;
    end else begin
      o_ctrl_wr <= wr_acc && bus.spi_addr == ADDR_CTRL;
      if (wr_acc && bus.spi_addr == ADDR_CTRL) begin
        o_ctrl <= bus.spi_data;
      end
      for (int k = 0; k < NUM_GP; k++) begin
        if (wr_acc && gp_sel[k]) begin
          gp_q[k] <= bus.spi_data;
        end
      end
      status_q <= status_nxt;
      mask_q   <= mask_nxt;
      o_irq    <= |(status_nxt & mask_nxt);
    end
  end

  // Write counter (wrapping) and error logging (saturating count).
  always_ff @(posedge master_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_count_q  <= '0;
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      if (wr_acc && writable) begin
        wr_count_q <= wr_count_q + 1'b1;
      end
      if (log_err) begin
        err_addr_q <= bus.spi_addr;
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + 1'b1;
        end
      end
    end
  end

  // Read data is captured on the accepted read and held until the next one.
  always_ff @(posedge master_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.data_word_send <= '0;
    end else if (rd_acc) begin
      bus.data_word_send <= rd_data;
    end
  end

endmodule
